// File: rtl/axi_rd_arbiter_pkg.sv
// axi_pkg: constants shared by the AXI read/write arbiters.
//   AXI_BURST_INCR / AXI_LEN_SINGLE : fixed single-beat INCR bursts
//   SIZE_BYTE / SIZE_HALF / SIZE_WORD : sram-like size codes
//   ARB_IDLE / ARB_ISSUE : arbiter state encodings
//   axi_size() : sram-like 2-bit size to AXI 3-bit arsize/awsize
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_ISSUE = 1'b1;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_rr_age_prio.sv
// rr_age_prio: two-requester fixed-priority arbiter with aging.
// The "hi" requester wins by default; the "lo" requester is forced a grant
// once it has lost STARVE_LIMIT consecutive arbitrations while eligible.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   arb_en              : arbitration allowed this cycle
//   lo_req / lo_busy    : aged requester request / already has one outstanding
//   hi_req / hi_busy    : preferred requester request / already outstanding
//   lo_grant / hi_grant : combinational one-hot grant (zero when !arb_en)
module rr_age_prio #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en,
  input  logic lo_req,
  input  logic lo_busy,
  input  logic hi_req,
  input  logic hi_busy,
  output logic lo_grant,
  output logic hi_grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  logic       lo_elig, hi_elig, lo_forced;

  always_comb begin
    lo_elig   = lo_req && !lo_busy;
    hi_elig   = hi_req && !hi_busy;
    lo_forced = lo_elig && (starve_q == LIMIT);
    hi_grant  = arb_en && hi_elig && !lo_forced;
    lo_grant  = arb_en && lo_elig && !hi_grant;

    // Counts only arbitrations the lo side actually lost; any cycle where it
    // is not asking (or wins) restarts the age.
    starve_d = starve_q;
    if (!lo_elig || lo_grant) begin
      starve_d = '0;
    end else if (hi_grant && (starve_q != LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read channel (AR + R) between the
// instruction-fetch (inst_*) and data-load (data_*) sram-like read ports.
// Data has priority; instruction fetch is aged so it cannot starve.
// Each port has at most one read outstanding; R beats are routed by rid.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   inst_req/addr/size, *_addr_ok  : I request side, accept strobe
//   inst_data_ok, inst_rdata       : I read data return
//   data_req/addr/size, *_addr_ok  : D request side, accept strobe
//   data_data_ok, data_rdata       : D read data return
//   ar*                            : AXI read-address master channel
//   r*                             : AXI read-data channel (rlast ignored)
//   rid_err                        : sticky, R beat with no matching read
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter logic [3:0]  INST_ID      = 4'd0,
  parameter logic [3:0]  DATA_ID      = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic [1:0]  inst_size,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rid_err
);

  logic [0:0]  state_q, state_d;
  logic        out_i_q, out_i_d;
  logic        out_d_q, out_d_d;
  logic        rid_err_q, rid_err_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arid_q, arid_d;
  logic [2:0]  arsize_q, arsize_d;

  logic arb_en, grant_i, grant_d;
  logic ar_hs, r_beat, hit_i, hit_d;
  logic unused_rlast;

  assign unused_rlast = rlast;

  rr_age_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk     (clk),
    .reset   (reset),
    .arb_en  (arb_en),
    .lo_req  (inst_req),
    .lo_busy (out_i_q),
    .hi_req  (data_req),
    .hi_busy (out_d_q),
    .lo_grant(grant_i),
    .hi_grant(grant_d)
  );

  always_comb begin
    arb_en  = (state_q == ARB_IDLE) && !reset;
    arvalid = (state_q == ARB_ISSUE) && !reset;
    rready  = !reset;
    ar_hs   = arvalid && arready;
    r_beat  = rvalid && rready;
    hit_i   = r_beat && (rid == INST_ID) && out_i_q;
    hit_d   = r_beat && (rid == DATA_ID) && out_d_q;

    inst_addr_ok = grant_i;
    data_addr_ok = grant_d;
    inst_data_ok = hit_i;
    data_data_ok = hit_d;
    inst_rdata   = hit_i ? rdata : '0;
    data_rdata   = hit_d ? rdata : '0;

    arid    = arid_q;
    araddr  = araddr_q;
    arsize  = arsize_q;
    arlen   = AXI_LEN_SINGLE;
    arburst = AXI_BURST_INCR;
    rid_err = rid_err_q;

    state_d = state_q;
    if (state_q == ARB_IDLE) begin
      if (grant_i || grant_d) state_d = ARB_ISSUE;
    end else if (ar_hs) begin
      state_d = ARB_IDLE;
    end

    araddr_d = araddr_q;
    arid_d   = arid_q;
    arsize_d = arsize_q;
    if (grant_d) begin
      araddr_d = data_addr;
      arid_d   = DATA_ID;
      arsize_d = axi_size(data_size);
    end else if (grant_i) begin
      araddr_d = inst_addr;
      arid_d   = INST_ID;
      arsize_d = axi_size(inst_size);
    end

    // A port's own response and its AR handshake cannot coincide (the flag
    // is clear during its ISSUE), so the set/clear order here is immaterial.
    out_i_d = out_i_q;
    if (hit_i) out_i_d = 1'b0;
    if (ar_hs && (arid_q == INST_ID)) out_i_d = 1'b1;

    out_d_d = out_d_q;
    if (hit_d) out_d_d = 1'b0;
    if (ar_hs && (arid_q == DATA_ID)) out_d_d = 1'b1;

    rid_err_d = rid_err_q || (r_beat && !hit_i && !hit_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      out_i_q   <= 1'b0;
      out_d_q   <= 1'b0;
      rid_err_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      arsize_q  <= '0;
    end else begin
      state_q   <= state_d;
      out_i_q   <= out_i_d;
      out_d_q   <= out_d_d;
      rid_err_q <= rid_err_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      arsize_q  <= arsize_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam logic [3:0]  IID   = 4'd0;
  localparam logic [3:0]  DID   = 4'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = '0, data_addr = '0;
  logic [1:0]  inst_size = '0, data_size = '0;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arvalid, arready = 1'b0;
  logic [3:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic        rlast = 1'b1, rvalid = 1'b0, rready, rid_err;

  always #5 clk = ~clk;

  axi_rd_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .INST_ID     (IID),
    .DATA_ID     (DID)
  ) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arsize(arsize), .arlen(arlen), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rid_err(rid_err)
  );

  // Expected per-cycle strobes and expected AR / data transactions.
  typedef struct packed {
    logic rst, gi, gd, arv, iok, dok, err;
  } cyc_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  cyc_t        cyc_q[$];
  ar_t         ar_q[$];
  logic [31:0] i_q[$], d_q[$];
  int          vectors = 0, errors = 0;
  bit          done = 0;

  // Reference model: which ports hold an outstanding read, whether an
  // accepted request is still waiting for its AR handshake, the age of I.
  bit          m_out_i, m_out_d, m_err, ar_busy;
  ar_t         ar_cur;
  int          starve;
  logic [3:0]  slave_q[$];   // ids the AXI slave still owes a beat for

  task automatic step(input bit rst,
                      input bit ireq, input logic [31:0] ia, input logic [1:0] is,
                      input bit dreq, input logic [31:0] da, input logic [1:0] ds,
                      input bit ardy, input bit rv, input logic [3:0] rid_v,
                      input logic [31:0] rd);
    cyc_t e;
    bit ei, ed, gi, gd, hi, hd;
    @(posedge clk);
    #1;
    reset = rst; inst_req = ireq; inst_addr = ia; inst_size = is;
    data_req = dreq; data_addr = da; data_size = ds; arready = ardy;
    rvalid = rv; rid = rid_v; rdata = rd;
    e = '0;
    e.rst = rst;
    e.err = m_err;
    if (rst) begin
      m_out_i = 0; m_out_d = 0; m_err = 0; ar_busy = 0; starve = 0;
      ar_q.delete();
      cyc_q.push_back(e);
      return;
    end
    ei = ireq && !m_out_i;
    ed = dreq && !m_out_d;
    gd = !ar_busy && ed && !(ei && starve == int'(LIMIT));
    gi = !ar_busy && ei && !gd;
    hi = rv && rid_v == IID && m_out_i;
    hd = rv && rid_v == DID && m_out_d;
    e.gi = gi; e.gd = gd; e.arv = ar_busy; e.iok = hi; e.dok = hd;
    if (hi) i_q.push_back(rd);
    if (hd) d_q.push_back(rd);
    if (rv && !hi && !hd) m_err = 1;
    if (rv) begin
      for (int k = 0; k < slave_q.size(); k++)
        if (slave_q[k] == rid_v) begin slave_q.delete(k); break; end
    end
    if (hi) m_out_i = 0;
    if (hd) m_out_d = 0;
    if (ar_busy && ardy) begin
      if (ar_cur.id == IID) m_out_i = 1; else m_out_d = 1;
      slave_q.push_back(ar_cur.id);
      ar_busy = 0;
    end
    if (gi || gd) begin
      ar_cur = gd ? '{id: DID, addr: da, size: {1'b0, ds}}
                  : '{id: IID, addr: ia, size: {1'b0, is}};
      ar_q.push_back(ar_cur);
      ar_busy = 1;
    end
    if (!ei || gi) starve = 0;
    else if (gd && starve < int'(LIMIT)) starve++;
    cyc_q.push_back(e);
  endtask

  task automatic quiet(input int n, input bit ardy);
    for (int k = 0; k < n; k++) step(0, 0, '0, '0, 0, '0, '0, ardy, 0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) step(1, 0, '0, '0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic beat(input logic [3:0] id, input logic [31:0] d);
    step(0, 0, '0, '0, 0, '0, '0, 0, 1, id, d);
  endtask

  task automatic rand_phase(input int n, input int ipct, input int dpct, input int apct,
                            input int rpct, input int bpct, input int rstpct);
    for (int c = 0; c < n; c++) begin
      bit rv;
      logic [3:0] r;
      rv = 0; r = '0;
      if ($urandom_range(99) < rstpct) begin
        step(1, 0, '0, '0, 0, '0, '0, 0, 0, '0, '0);
      end else begin
        if (slave_q.size() > 0 && $urandom_range(99) < rpct) begin
          rv = 1;
          r = slave_q[$urandom_range(slave_q.size() - 1)];
        end else if ($urandom_range(99) < bpct) begin
          rv = 1;
          r = 4'($urandom_range(15));
        end
        step(0, $urandom_range(99) < ipct, $urandom, 2'($urandom_range(2)),
             $urandom_range(99) < dpct, $urandom, 2'($urandom_range(2)),
             $urandom_range(99) < apct, rv, r, $urandom);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: one expected-strobe entry per cycle, plus popped
  // AR and data expectations whenever the DUT presents a transfer.
  initial begin : monitor
    cyc_t e;
    ar_t  a;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc_q.size() == 0) continue;
      e = cyc_q.pop_front();
      chk("strobes{iaok,daok,arvalid,idok,ddok,rid_err}",
          {inst_addr_ok, data_addr_ok, arvalid, inst_data_ok, data_data_ok, rid_err},
          {e.gi, e.gd, e.arv, e.iok, e.dok, e.err});
      if (!e.rst) chk("rready", rready, 1'b1);
      if (inst_data_ok) begin
        if (i_q.size() == 0) chk("inst_data_unexpected", 1, 0);
        else chk("inst_rdata", inst_rdata, i_q.pop_front());
      end else chk("inst_rdata_idle", inst_rdata, 0);
      if (data_data_ok) begin
        if (d_q.size() == 0) chk("data_data_unexpected", 1, 0);
        else chk("data_rdata", data_rdata, d_q.pop_front());
      end else chk("data_rdata_idle", data_rdata, 0);
      if (arvalid && arready) begin
        if (ar_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          a = ar_q.pop_front();
          chk("ar{id,addr,size}", {arid, araddr, arsize}, a);
          chk("ar{len,burst}", {arlen, arburst}, {8'd0, 2'b01});
        end
      end
    end
    chk("inst_data_missing", i_q.size(), 0);
    chk("data_data_missing", d_q.size(), 0);
    chk("ar_missing", ar_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    m_out_i = 0; m_out_d = 0; m_err = 0; ar_busy = 0; starve = 0;
    do_reset(3);

    // I fetch alone, AR stalled two cycles, then its data comes back.
    step(0, 1, 32'hBFC0_0000, 2'd2, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    beat(IID, 32'h2408_0001);
    quiet(2, 0);

    // Byte load at an unaligned address.
    step(0, 0, '0, '0, 1, 32'h8000_0003, 2'd0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    beat(DID, 32'h1234_5678);
    quiet(1, 0);

    // Both outstanding, D answered first while D re-requests; I answered
    // in the same cycle the new D request is granted.
    step(0, 1, 32'h0000_1000, 2'd2, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    step(0, 0, '0, '0, 1, 32'h0000_2000, 2'd1, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    step(0, 0, '0, '0, 1, 32'h0000_2004, 2'd2, 0, 1, DID, 32'hDDDD_0001);
    step(0, 0, '0, '0, 1, 32'h0000_2004, 2'd2, 0, 1, IID, 32'h1111_0001);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    beat(DID, 32'hDDDD_0002);
    quiet(1, 0);

    // Stray beats: unknown id, then a known id with nothing outstanding.
    beat(4'd3, 32'hBAD0_0003);
    quiet(2, 0);
    beat(IID, 32'hBAD0_0000);
    quiet(3, 0);

    // Reset while an I request waits in ISSUE and a D read is in flight.
    do_reset(1);
    step(0, 0, '0, '0, 1, 32'h0000_3000, 2'd2, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 1, 0, '0, '0);
    step(0, 1, 32'h0000_4000, 2'd2, 0, '0, '0, 0, 0, '0, '0);
    step(0, 0, '0, '0, 0, '0, '0, 0, 0, '0, '0);
    do_reset(1);
    quiet(1, 0);
    beat(DID, 32'hDEAD_0001);
    quiet(3, 0);

    // Randomized traffic.
    do_reset(1);
    rand_phase(200, 100, 100, 100, 100, 0, 0);
    rand_phase(1500, 50, 50, 50, 40, 0, 0);
    rand_phase(400, 60, 60, 60, 40, 2, 2);
    rand_phase(400, 30, 80, 30, 20, 0, 1);

    // Drain everything still owed.
    for (int k = 0; k < 50 && (ar_busy || slave_q.size() > 0); k++) begin
      if (slave_q.size() > 0) step(0, 0, '0, '0, 0, '0, '0, 1, 1, slave_q[0], $urandom);
      else quiet(1, 1);
    end
    quiet(2, 0);
    @(negedge clk);
    #1;
    done = 1;
  end

endmodule
